instruction_fetch_unit: RTL and testbench

Fetch stage of the 16-bit pipelined RISC core. It sits directly upstream of instruction_memory and owns the program counter. It drives read_address to the asynchronous-read instruction memory and latches the returned 16-bit instruction into the IF/ID pipeline register. It also handles pipeline stall, taken-branch redirect with squash, and HALT detection.

---
 rtl/instruction_fetch_unit_if.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 77 +++++++
 tb/tb_instruction_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, hazard/branch controls and IF/ID outputs.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
);

  localparam int unsigned CNT_WIDTH = 16;

  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  stall;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] ifid_instruction;
  logic [ADDR_WIDTH-1:0] ifid_pc;
  logic [ADDR_WIDTH-1:0] ifid_pc_plus1;
  logic                  ifid_valid;
  logic                  halted;
  logic [CNT_WIDTH-1:0]  fetch_count;

  // Fetch unit side
  modport master (
    output read_address,
    input  instruction,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output ifid_instruction,
    output ifid_pc,
    output ifid_pc_plus1,
    output ifid_valid,
    output halted,
    output fetch_count
  );

  // Memory / pipeline / hazard side
  modport slave (
    input  read_address,
    output instruction,
    output stall,
    output branch_taken,
    output branch_target,
    input  ifid_instruction,
    input  ifid_pc,
    input  ifid_pc_plus1,
    input  ifid_valid,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, fills the IF/ID register,
// and handles stall, taken-branch redirect with squash, and HALT.
module instruction_fetch_unit #(
  parameter int unsigned          ADDR_WIDTH  = 6,
  parameter int unsigned          DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0,
  parameter logic [3:0]           HALT_OPCODE = 4'hF
) (
  input  logic clk,
  input  logic rst,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned OPC_WIDTH = 4;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus1_c;
  logic                  is_halt_c;
  logic [DATA_WIDTH-1:0] ifid_instruction;
  logic [ADDR_WIDTH-1:0] ifid_pc;
  logic [ADDR_WIDTH-1:0] ifid_pc_plus1;
  logic                  ifid_valid;
  logic                  halted;
  logic [CNT_WIDTH-1:0]  fetch_count;

  // Next sequential address (wraps at the top of memory) and HALT decode
  assign pc_plus1_c = pc + ADDR_WIDTH'(1);
  assign is_halt_c  = (bus.instruction[DATA_WIDTH-1 -: OPC_WIDTH] == HALT_OPCODE);

  // Memory is async-read, so the address is the live PC
  assign bus.read_address     = pc;
  assign bus.ifid_instruction = ifid_instruction;
  assign bus.ifid_pc          = ifid_pc;
  assign bus.ifid_pc_plus1    = ifid_pc_plus1;
  assign bus.ifid_valid       = ifid_valid;
  assign bus.halted           = halted;
  assign bus.fetch_count      = fetch_count;

  // PC and IF/ID update; priority is redirect > halted > stall > fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= RESET_PC;
      ifid_instruction <= NOP_INSTR;
      ifid_pc          <= '0;
      ifid_pc_plus1    <= '0;
      ifid_valid       <= 1'b0;
      halted           <= 1'b0;
      fetch_count      <= '0;
    end else if (bus.branch_taken) begin
      // A halt behind a taken branch was speculative, so it is cleared too
      pc               <= bus.branch_target;
      ifid_instruction <= NOP_INSTR;
      ifid_valid       <= 1'b0;
      halted           <= 1'b0;
    end else if (halted) begin
      ifid_instruction <= NOP_INSTR;
      ifid_valid       <= 1'b0;
    end else if (!bus.stall) begin
      ifid_instruction <= bus.instruction;
      ifid_pc          <= pc;
      ifid_pc_plus1    <= pc_plus1_c;
      ifid_valid       <= 1'b1;
      if (fetch_count != {CNT_WIDTH{1'b1}}) begin
        fetch_count <= fetch_count + CNT_WIDTH'(1);
      end
      // The HALT word itself is delivered; the PC parks on it
      if (is_halt_c) begin
        halted <= 1'b1;
      end else begin
        pc <= pc_plus1_c;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [15:0] mem [0:63];

  instruction_fetch_unit_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

  instruction_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.instruction = mem[bus.read_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".read_address"}, 32'(bus.read_address), 32'd0);
    check({tag, ".ifid_instr"},   32'(bus.ifid_instruction), 32'h0000);
    check({tag, ".ifid_pc"},      32'(bus.ifid_pc), 32'd0);
    check({tag, ".ifid_pc1"},     32'(bus.ifid_pc_plus1), 32'd0);
    check({tag, ".ifid_valid"},   32'(bus.ifid_valid), 32'd0);
    check({tag, ".halted"},       32'(bus.halted), 32'd0);
    check({tag, ".fetch_count"},  32'(bus.fetch_count), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;

    // 1: reset state, then four clean fetches
    @(negedge clk);
    @(negedge clk);
    check_reset_state("t1_reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_instr", 32'(bus.ifid_instruction), 32'h1000 + 32'(i));
      check("t1_pc",    32'(bus.ifid_pc), 32'(i));
      check("t1_valid", 32'(bus.ifid_valid), 32'd1);
    end
    check("t1_count", 32'(bus.fetch_count), 32'd4);
    check("t1_raddr", 32'(bus.read_address), 32'd4);

    // 2: redirect to 62 and wrap through 63 -> 0
    bus.branch_taken = 1'b1; bus.branch_target = 6'd62;
    tick();
    bus.branch_taken = 1'b0;
    check("t2_sq_valid", 32'(bus.ifid_valid), 32'd0);
    check("t2_sq_instr", 32'(bus.ifid_instruction), 32'h0000);
    check("t2_sq_pc",    32'(bus.ifid_pc), 32'd3);
    check("t2_sq_raddr", 32'(bus.read_address), 32'd62);
    check("t2_sq_count", 32'(bus.fetch_count), 32'd4);
    tick();
    check("t2_pc62",  32'(bus.ifid_pc), 32'd62);
    check("t2_p1_63", 32'(bus.ifid_pc_plus1), 32'd63);
    check("t2_ra63",  32'(bus.read_address), 32'd63);
    tick();
    check("t2_pc63",  32'(bus.ifid_pc), 32'd63);
    check("t2_p1_0",  32'(bus.ifid_pc_plus1), 32'd0);
    check("t2_ra0",   32'(bus.read_address), 32'd0);
    tick();
    check("t2_pc0",   32'(bus.ifid_pc), 32'd0);
    check("t2_p1_1",  32'(bus.ifid_pc_plus1), 32'd1);
    check("t2_instr", 32'(bus.ifid_instruction), 32'h1000);
    check("t2_count", 32'(bus.fetch_count), 32'd7);

    // 3: fetch word 4, then stall three cycles at pc=5
    bus.branch_taken = 1'b1; bus.branch_target = 6'd4;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    check("t3_pc4",    32'(bus.ifid_pc), 32'd4);
    check("t3_count8", 32'(bus.fetch_count), 32'd8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_st_raddr", 32'(bus.read_address), 32'd5);
      check("t3_st_pc",    32'(bus.ifid_pc), 32'd4);
      check("t3_st_instr", 32'(bus.ifid_instruction), 32'h1004);
      check("t3_st_valid", 32'(bus.ifid_valid), 32'd1);
      check("t3_st_count", 32'(bus.fetch_count), 32'd8);
    end
    bus.stall = 1'b0;
    tick();
    check("t3_rel_pc",    32'(bus.ifid_pc), 32'd5);
    check("t3_rel_instr", 32'(bus.ifid_instruction), 32'h1005);
    check("t3_rel_count", 32'(bus.fetch_count), 32'd9);

    // 4: redirect with stall at pc=8
    bus.branch_taken = 1'b1; bus.branch_target = 6'd8;
    tick();
    check("t4_ra8", 32'(bus.read_address), 32'd8);
    bus.branch_target = 6'd20; bus.stall = 1'b1;
    tick();
    bus.branch_taken = 1'b0; bus.stall = 1'b0;
    check("t4_valid0", 32'(bus.ifid_valid), 32'd0);
    check("t4_instr0", 32'(bus.ifid_instruction), 32'h0000);
    check("t4_ra20",   32'(bus.read_address), 32'd20);
    check("t4_count",  32'(bus.fetch_count), 32'd9);
    tick();
    check("t4_pc20",   32'(bus.ifid_pc), 32'd20);
    check("t4_valid1", 32'(bus.ifid_valid), 32'd1);
    check("t4_instr",  32'(bus.ifid_instruction), 32'h1014);
    check("t4_count2", 32'(bus.fetch_count), 32'd10);

    // 5: HALT at word 3, stall toggling while halted, then redirect to 10
    mem[3] = 16'hF000;
    bus.branch_taken = 1'b1; bus.branch_target = 6'd2;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    check("t5_pc2", 32'(bus.ifid_pc), 32'd2);
    tick();
    check("t5_hinstr", 32'(bus.ifid_instruction), 32'hF000);
    check("t5_hvalid", 32'(bus.ifid_valid), 32'd1);
    check("t5_halted", 32'(bus.halted), 32'd1);
    check("t5_hpc",    32'(bus.ifid_pc), 32'd3);
    check("t5_hraddr", 32'(bus.read_address), 32'd3);
    check("t5_hcount", 32'(bus.fetch_count), 32'd12);
    for (int i = 0; i < 4; i++) begin
      bus.stall = ((i % 2) == 0);
      tick();
      check("t5_h_valid",  32'(bus.ifid_valid), 32'd0);
      check("t5_h_instr",  32'(bus.ifid_instruction), 32'h0000);
      check("t5_h_raddr",  32'(bus.read_address), 32'd3);
      check("t5_h_halted", 32'(bus.halted), 32'd1);
      check("t5_h_count",  32'(bus.fetch_count), 32'd12);
    end
    bus.stall = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 6'd10;
    tick();
    bus.branch_taken = 1'b0;
    check("t5_unhalt", 32'(bus.halted), 32'd0);
    check("t5_ra10",   32'(bus.read_address), 32'd10);
    tick();
    check("t5_pc10",   32'(bus.ifid_pc), 32'd10);
    check("t5_instr",  32'(bus.ifid_instruction), 32'h100A);
    check("t5_count",  32'(bus.fetch_count), 32'd13);

    // 5b: stall while HALT is presented, then branch on the HALT edge
    bus.branch_taken = 1'b1; bus.branch_target = 6'd3; bus.stall = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    check("t5b_st_halted", 32'(bus.halted), 32'd0);
    check("t5b_st_valid",  32'(bus.ifid_valid), 32'd0);
    check("t5b_st_count",  32'(bus.fetch_count), 32'd13);
    check("t5b_st_raddr",  32'(bus.read_address), 32'd3);
    bus.stall = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 6'd7;
    tick();
    bus.branch_taken = 1'b0;
    check("t5b_br_halted", 32'(bus.halted), 32'd0);
    check("t5b_br_valid",  32'(bus.ifid_valid), 32'd0);
    check("t5b_br_instr",  32'(bus.ifid_instruction), 32'h0000);
    check("t5b_br_raddr",  32'(bus.read_address), 32'd7);
    check("t5b_br_count",  32'(bus.fetch_count), 32'd13);
    tick();
    check("t5b_pc7",   32'(bus.ifid_pc), 32'd7);
    check("t5b_instr", 32'(bus.ifid_instruction), 32'h1007);
    check("t5b_count", 32'(bus.fetch_count), 32'd14);

    // 6: asynchronous reset mid-cycle at pc=12, then restart from 0
    bus.branch_taken = 1'b1; bus.branch_target = 6'd12;
    tick();
    bus.branch_taken = 1'b0;
    check("t6_ra12", 32'(bus.read_address), 32'd12);
    #2 rst = 1'b1;
    #1 check_reset_state("t6_async");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_instr", 32'(bus.ifid_instruction), 32'h1000);
    check("t6_pc",    32'(bus.ifid_pc), 32'd0);
    check("t6_valid", 32'(bus.ifid_valid), 32'd1);
    check("t6_count", 32'(bus.fetch_count), 32'd1);
    check("t6_raddr", 32'(bus.read_address), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
